// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: sequencer in front of scan_flag_generate.
// One accepted host request runs START -> (DELAY) -> FBC -> RUN -> STOP -> DONE
// for a latched 3-channel PMT mask. An abort jumps straight to STOP.
// Every output is registered and derived from the next state, so each output
// is aligned with the state it belongs to and never glitches.
module scan_seq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int PULSE_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scan_req_i,
  input  logic [2:0]       scan_mask_i,
  input  logic [CNT_W-1:0] fbc_delay_i,
  input  logic [CNT_W-1:0] scan_len_i,
  input  logic             abort_i,
  output logic [2:0]       pmt_start_en_o,
  output logic [2:0]       pmt_end_en_o,
  output logic             fbc_up_start_o,
  output logic [2:0]       fbc_up_end_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DELAY, S_FBC, S_RUN, S_STOP, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [2:0]       mask_q, mask_d;
  logic             accept;
  logic             abort_take;
  logic             cnt_zero;

  // A request is only taken from IDLE with at least one channel enabled.
  assign accept     = (state_q == S_IDLE) && scan_req_i && (scan_mask_i != 3'b000);
  // Abort only matters while the sequence has not yet reached its end phase.
  assign abort_take = abort_i && ((state_q == S_START) || (state_q == S_DELAY) ||
                                  (state_q == S_FBC)   || (state_q == S_RUN));
  assign cnt_zero   = (cnt_q == '0);

  // State, counter and latched request parameters.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      len_q   <= '0;
      mask_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state decode; abort overrides normal progression in START..RUN.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: begin
        if (abort_take)    state_d = S_STOP;
        else if (cnt_zero) state_d = (dly_q == '0) ? S_FBC : S_DELAY;
      end
      S_DELAY: begin
        if (abort_take)    state_d = S_STOP;
        else if (cnt_zero) state_d = S_FBC;
      end
      S_FBC:   state_d = abort_take ? S_STOP : S_RUN;
      S_RUN: begin
        if (abort_take || cnt_zero) state_d = S_STOP;
      end
      S_STOP:  if (cnt_zero) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter reload on state entry (cycles remaining minus one), else count down to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      unique case (state_d)
        S_START: cnt_d = PULSE_CNT;
        S_DELAY: cnt_d = dly_q - CNT_ONE;
        S_RUN:   cnt_d = (len_q == '0) ? '0 : len_q - CNT_ONE;
        S_STOP:  cnt_d = PULSE_CNT;
        default: cnt_d = '0;
      endcase
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Request parameters are captured only on an accepted request.
  always_comb begin
    mask_d = mask_q;
    dly_d  = dly_q;
    len_d  = len_q;
    if (accept) begin
      mask_d = scan_mask_i;
      dly_d  = fbc_delay_i;
      len_d  = scan_len_i;
    end
  end

  // Output decode from the next state, registered below.
  logic [2:0] start_en_d, end_en_d, fbc_end_d;
  logic       fbc_start_d, busy_d, done_d, aborted_d, err_d;

  always_comb begin
    start_en_d  = (state_d == S_START) ? mask_d : 3'b000;
    end_en_d    = (state_d == S_STOP)  ? mask_d : 3'b000;
    fbc_end_d   = (state_d == S_STOP)  ? mask_d : 3'b000;
    fbc_start_d = (state_d == S_FBC);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    err_d       = scan_req_i && !accept;
    aborted_d   = aborted_o;
    if (accept)          aborted_d = 1'b0;
    else if (abort_take) aborted_d = 1'b1;
  end

  // Registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pmt_start_en_o <= 3'b000;
      pmt_end_en_o   <= 3'b000;
      fbc_up_start_o <= 1'b0;
      fbc_up_end_o   <= 3'b000;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      aborted_o      <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      pmt_start_en_o <= start_en_d;
      pmt_end_en_o   <= end_en_d;
      fbc_up_start_o <= fbc_start_d;
      fbc_up_end_o   <= fbc_end_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      aborted_o      <= aborted_d;
      err_o          <= err_d;
    end
  end

endmodule
